// File: rtl/led_mode_ctrl_pkg.sv
// led_mode_ctrl_pkg: mode encodings, blink phase count and bounce direction codes
package led_mode_ctrl_pkg;
  localparam logic [1:0] MODE_OFF = 2'd0;
  localparam logic [1:0] MODE_BLINK = 2'd1;
  localparam logic [1:0] MODE_CHASE = 2'd2;
  localparam logic [1:0] MODE_BOUNCE = 2'd3;
  localparam int BLINK_PHASES = 5;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;
endpackage

// File: rtl/led_mode_ctrl_if.sv
// led_mode_ctrl_if: button/enable inputs and LED/mode outputs of the LED mode controller
interface led_mode_ctrl_if #(parameter int NLED = 4);
  logic btn;
  logic en;
  logic [NLED-1:0] LED;
  logic [1:0] mode;
  modport master(output btn, en, input LED, mode);
  modport slave(input btn, en, output LED, mode);
endinterface

// File: rtl/led_mode_ctrl_btn_debounce.sv
// btn_debounce: synchronises the raw button, debounces it and pulses adv on each press
module btn_debounce #(
  parameter int DEB_CYC = 1_000_000
) (
  input  logic ck,
  input  logic r,
  input  logic btn,
  output logic adv
);
  localparam int DW = DEB_CYC > 1 ? $clog2(DEB_CYC) : 1;
  logic s1, s2, deb, deb_q;
  logic [DW-1:0] dc;
  always_ff @(posedge ck or negedge r) begin
    if (!r) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      deb <= 1'b0;
      deb_q <= 1'b0;
      dc <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      deb_q <= deb;
      if (s2 == deb) dc <= '0;
      else if (dc == DW'(DEB_CYC - 1)) begin
        deb <= s2;
        dc <= '0;
      end else dc <= dc + 1'b1;
    end
  end
  // only presses advance the mode; releases are debounced but otherwise ignored
  assign adv = deb & ~deb_q;
endmodule

// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: button-stepped OFF/BLINK/CHASE/BOUNCE LED pattern driver with shared tick prescaler
module led_mode_ctrl
  import led_mode_ctrl_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int TICK_DIV = 5_000_000,
  parameter int DEB_CYC = 1_000_000,
  parameter int NLED = 4
) (
  input logic ck,
  input logic r,
  led_mode_ctrl_if.slave io
);
  localparam int PW = $clog2(TICK_DIV);
  if (TICK_DIV < 2 || DEB_CYC < 1 || NLED < 2 || CLK_HZ < TICK_DIV) begin : g_bad_params
    $error("led_mode_ctrl: invalid parameters");
  end
  logic adv, tick, dir, nxt_dir, bnc_dn;
  logic [PW-1:0] pc;
  logic [2:0] phase, nxt_phase;
  logic [1:0] mode, nxt_mode;
  logic [NLED-1:0] led, pat, entry;
  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb (.ck(ck), .r(r), .btn(io.btn), .adv(adv));
  assign tick = io.en && pc == PW'(TICK_DIV - 1);
  always_comb begin
    nxt_mode = mode + 2'd1;
    entry = nxt_mode == MODE_OFF ? '0 : nxt_mode == MODE_BLINK ? '1 : NLED'(1);
    bnc_dn = dir == DIR_UP ? led[NLED-1] : !led[0];
    pat = mode == MODE_BLINK ? (phase == 3'(BLINK_PHASES - 1) ? ~led : led) :
          mode == MODE_CHASE ? {led[NLED-2:0], led[NLED-1]} :
          mode == MODE_BOUNCE ? (bnc_dn ? led >> 1 : led << 1) : '0;
    nxt_dir = mode == MODE_BOUNCE ? (bnc_dn ? DIR_DN : DIR_UP) : dir;
    nxt_phase = mode != MODE_BLINK ? phase : phase == 3'(BLINK_PHASES - 1) ? 3'd0 : phase + 3'd1;
  end
  // a press restarts the pattern from its entry value, swallowing any coincident tick
  always_ff @(posedge ck or negedge r) begin
    if (!r) begin
      mode <= MODE_OFF;
      led <= '0;
      pc <= '0;
      phase <= '0;
      dir <= DIR_UP;
    end else if (adv) begin
      mode <= nxt_mode;
      led <= entry;
      pc <= '0;
      phase <= '0;
      dir <= DIR_UP;
    end else if (io.en) begin
      pc <= tick ? '0 : pc + 1'b1;
      if (tick) begin
        led <= pat;
        phase <= nxt_phase;
        dir <= nxt_dir;
      end
    end
  end
  assign io.LED = led;
  assign io.mode = mode;
endmodule

// File: tb/tb_led_mode_ctrl.sv
// tb_led_mode_ctrl: directed stimulus with a tick-count pattern model and per-cycle output checks
module tb_led_mode_ctrl;
  localparam int TD = 4, DC = 3, N = 4;
  logic ck = 1'b0, r = 1'b0;
  int total = 0, bad = 0;
  int m_mode, n, run;
  logic s1, s2, deb, pend;
  always #10 ck = ~ck;
  led_mode_ctrl_if #(.NLED(N)) io ();
  led_mode_ctrl #(.TICK_DIV(TD), .DEB_CYC(DC), .NLED(N)) dut (.ck(ck), .r(r), .io(io.slave));
  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // pattern as a pure function of mode and enabled cycles since mode entry
  function automatic logic [N-1:0] exp_led(int md, int cnt);
    int k, p;
    k = cnt / TD;
    p = k % (2 * N - 2);
    case (md)
      1: return ((k / 5) % 2) != 0 ? '0 : '1;
      2: return N'(1) << (k % N);
      3: return N'(1) << (p < N ? p : 2 * N - 2 - p);
      default: return '0;
    endcase
  endfunction
  always @(posedge ck or negedge r) begin
    if (!r) begin
      m_mode = 0; n = 0; run = 0;
      s1 = 0; s2 = 0; deb = 0; pend = 0;
    end else begin
      if (pend) begin
        m_mode = (m_mode + 1) % 4;
        n = 0;
      end else if (io.en) n++;
      pend = 0;
      if (s2 != deb) begin
        run++;
        if (run == DC) begin
          deb = s2;
          run = 0;
          pend = s2;
        end
      end else run = 0;
      s2 = s1;
      s1 = io.btn;
    end
  end
  always @(negedge ck) begin
    #2;
    chk("mode", 8'(io.mode), 8'(m_mode));
    chk("led", 8'(io.LED), 8'(exp_led(m_mode, n)));
  end
  task automatic tk(int k);
    repeat (k) @(negedge ck);
    #3;
  endtask
  task automatic press_to(int m);
    io.btn = 1'b1;
    tk(6);
    chk("press_mode", 8'(io.mode), 8'(m));
    tk(4);
    io.btn = 1'b0;
  endtask
  initial begin
    logic [3:0] chase_seq [5];
    logic [3:0] bnc_seq [5];
    chase_seq = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
    bnc_seq = '{4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
    io.btn = 1'b1;
    io.en = 1'b1;
    tk(2);
    chk("rst_led", 8'(io.LED), 8'h0);
    chk("rst_mode", 8'(io.mode), 8'h0);
    r = 1'b1;
    io.btn = 1'b0;
    tk(50);
    chk("idle_mode", 8'(io.mode), 8'h0);
    chk("idle_led", 8'(io.LED), 8'h0);
    io.btn = 1'b1;
    tk(5);
    chk("pre_adv_mode", 8'(io.mode), 8'h0);
    tk(1);
    chk("adv_mode", 8'(io.mode), 8'h1);
    chk("blink_on", 8'(io.LED), 8'hf);
    tk(4);
    io.btn = 1'b0;
    tk(15);
    chk("blink_hold", 8'(io.LED), 8'hf);
    tk(1);
    chk("blink_off", 8'(io.LED), 8'h0);
    tk(20);
    chk("blink_on2", 8'(io.LED), 8'hf);
    for (int i = 0; i < 12; i++) begin
      io.btn = (i % 2) == 0;
      tk(1);
    end
    io.btn = 1'b0;
    tk(10);
    chk("glitch_mode", 8'(io.mode), 8'h1);
    press_to(2);
    chk("chase_1", 8'(io.LED), 8'h2);
    for (int i = 0; i < 5; i++) begin
      tk(4);
      chk("chase_seq", 8'(io.LED), 8'(chase_seq[i]));
    end
    io.en = 1'b0;
    tk(30);
    chk("freeze", 8'(io.LED), 8'h4);
    io.en = 1'b1;
    tk(3);
    chk("resume_early", 8'(io.LED), 8'h4);
    tk(1);
    chk("resume", 8'(io.LED), 8'h8);
    press_to(3);
    chk("bounce_1", 8'(io.LED), 8'h2);
    for (int i = 0; i < 5; i++) begin
      tk(4);
      chk("bounce_seq", 8'(io.LED), 8'(bnc_seq[i]));
    end
    tk(2);
    io.btn = 1'b1;
    tk(6);
    chk("coll_mode", 8'(io.mode), 8'h0);
    chk("coll_led", 8'(io.LED), 8'h0);
    tk(4);
    io.btn = 1'b0;
    tk(10);
    io.btn = 1'b1;
    tk(4);
    r = 1'b0;
    io.btn = 1'b0;
    tk(2);
    r = 1'b1;
    tk(20);
    chk("rst_deb_mode", 8'(io.mode), 8'h0);
    chk("rst_deb_led", 8'(io.LED), 8'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
